lut_client_arbiter: RTL and testbench

Initiator-side front end for the shared LUT responder. Collects table-lookup requests from up to `n_clients` DSP stages (oscillators, waveshapers), round-robin arbitrates them, and drives the responder's single `req`/`lut_handle`/`req_arg` port. It routes each `data_out`/`valid` result back to the client that issued it. It also detects the responder's sticky `invalid_request` and lost responses, and reports them as per-client errors.

---
 rtl/lut_client_arbiter_pkg.sv | 24 ++
 rtl/lut_client_arbiter_rr_arbiter.sv | 32 +++
 rtl/lut_client_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_lut_client_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_client_arbiter_pkg.sv
// Shared definitions for the LUT client arbiter: handle codes, FSM encodings
// and the round-robin pointer helper.
package lut_client_arbiter_pkg;

   localparam int LUT_HANDLE_WIDTH = 2;

   localparam logic [LUT_HANDLE_WIDTH-1:0] LUT_HANDLE_SIN  = 2'd0;
   localparam logic [LUT_HANDLE_WIDTH-1:0] LUT_HANDLE_TANH = 2'd1;

   typedef enum logic [2:0] {
      LUT_ARB_STATE_IDLE     = 3'd0,
      LUT_ARB_STATE_ISSUE    = 3'd1,
      LUT_ARB_STATE_WAIT     = 3'd2,
      LUT_ARB_STATE_RESP_OK  = 3'd3,
      LUT_ARB_STATE_RESP_ERR = 3'd4,
      LUT_ARB_STATE_FLT      = 3'd5
   } lut_arb_state_e;

   // Pointer value that follows a grant to idx among n clients.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/lut_client_arbiter_rr_arbiter.sv
// Combinational round-robin priority search: the first set request bit at or
// above ptr, wrapping around, is granted.
module rr_arbiter #(
   parameter int n  = 4,
   parameter int iw = 2
) (
   input  logic [n-1:0]  req,
   input  logic [iw-1:0] ptr,
   output logic [iw-1:0] grant_idx,
   output logic          any
);

   logic [iw-1:0] cand_s [n];

   // Candidate index for each search step, wrapped into 0..n-1.
   always_comb begin
      for (int k = 0; k < n; k++) begin
         cand_s[k] = (int'(ptr) + k >= n) ? iw'(int'(ptr) + k - n) : iw'(int'(ptr) + k);
      end
   end

   // First requester found along the search order wins.
   always_comb begin
      grant_idx = {iw{1'b0}};
      any       = 1'b0;
      for (int k = 0; k < n; k++) begin
         grant_idx = (!any && req[cand_s[k]]) ? cand_s[k] : grant_idx;
         any       = any | req[cand_s[k]];
      end
   end

endmodule

// File: rtl/lut_client_arbiter.sv
// Initiator-side front end for the shared LUT responder: round-robin arbitration
// of client lookups, result routing back to the issuer, fault/timeout reporting.
module lut_client_arbiter
   import lut_client_arbiter_pkg::*;
#(
   parameter int data_width     = 16,
   parameter int n_clients      = 4,
   parameter int timeout_cycles = 64
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [n_clients-1:0]                  cl_req,
   input  logic [n_clients*LUT_HANDLE_WIDTH-1:0] cl_handle,
   input  logic [n_clients*data_width-1:0]       cl_arg,
   output logic [data_width-1:0]                 cl_data,
   output logic [n_clients-1:0]                  cl_valid,
   output logic [n_clients-1:0]                  cl_error,
   output logic                                  fault,
   output logic                                  lut_req,
   output logic [LUT_HANDLE_WIDTH-1:0]           lut_handle,
   output logic [data_width-1:0]                 lut_arg,
   input  logic [data_width-1:0]                 lut_data,
   input  logic                                  lut_valid,
   input  logic                                  lut_invalid
);

   localparam int iw = (n_clients > 1) ? $clog2(n_clients) : 1;
   localparam int cw = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   localparam logic [cw-1:0] cnt_last = cw'(timeout_cycles - 1);

   lut_arb_state_e              state_q, state_d;
   logic [iw-1:0]               ptr_q, ptr_d;
   logic [iw-1:0]               grant_q, grant_d;
   logic [cw-1:0]               cnt_q, cnt_d;
   logic                        fault_q, fault_d;
   logic                        lut_req_q, lut_req_d;
   logic [LUT_HANDLE_WIDTH-1:0] lut_handle_q, lut_handle_d;
   logic [data_width-1:0]       lut_arg_q, lut_arg_d;
   logic [data_width-1:0]       cl_data_q, cl_data_d;
   logic [n_clients-1:0]        cl_valid_q, cl_valid_d;
   logic [n_clients-1:0]        cl_error_q, cl_error_d;

   logic [iw-1:0]               arb_idx_s;
   logic                        arb_any_s;
   logic [n_clients-1:0]        arb_oh_s;
   logic [n_clients-1:0]        grant_oh_s;
   logic [LUT_HANDLE_WIDTH-1:0] sel_handle_s;
   logic [data_width-1:0]       sel_arg_s;

   rr_arbiter #(
      .n  (n_clients),
      .iw (iw)
   ) u_rr (
      .req       (cl_req),
      .ptr       (ptr_q),
      .grant_idx (arb_idx_s),
      .any       (arb_any_s)
   );

   // One-hot masks for the arbiter winner and the in-flight grantee.
   always_comb begin
      arb_oh_s   = {{(n_clients-1){1'b0}}, 1'b1} << arb_idx_s;
      grant_oh_s = {{(n_clients-1){1'b0}}, 1'b1} << grant_q;
   end

   // Pick the winning client's handle and argument out of the packed buses.
   always_comb begin
      sel_handle_s = {LUT_HANDLE_WIDTH{1'b0}};
      sel_arg_s    = {data_width{1'b0}};
      for (int i = 0; i < n_clients; i++) begin
         sel_handle_s = (arb_idx_s == iw'(i)) ? cl_handle[i*LUT_HANDLE_WIDTH +: LUT_HANDLE_WIDTH] : sel_handle_s;
         sel_arg_s    = (arb_idx_s == iw'(i)) ? cl_arg[i*data_width +: data_width] : sel_arg_s;
      end
   end

   // Next-state and next-output logic of the transaction sequencer.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      fault_d      = fault_q | lut_invalid;
      lut_req_d    = 1'b0;
      lut_handle_d = lut_handle_q;
      lut_arg_d    = lut_arg_q;
      cl_data_d    = cl_data_q;
      cl_valid_d   = {n_clients{1'b0}};
      cl_error_d   = {n_clients{1'b0}};
      case (state_q)
         LUT_ARB_STATE_IDLE: begin
            if (fault_q) begin
               state_d = LUT_ARB_STATE_FLT;
            end else if (arb_any_s) begin
               grant_d      = arb_idx_s;
               ptr_d        = iw'(rr_next(int'(arb_idx_s), n_clients));
               lut_handle_d = sel_handle_s;
               lut_arg_d    = sel_arg_s;
               lut_req_d    = 1'b1;
               state_d      = LUT_ARB_STATE_ISSUE;
            end else begin
               state_d = LUT_ARB_STATE_IDLE;
            end
         end
         LUT_ARB_STATE_ISSUE: begin
            cnt_d   = {cw{1'b0}};
            state_d = LUT_ARB_STATE_WAIT;
         end
         LUT_ARB_STATE_WAIT: begin
            // A result beats a simultaneous invalid flag; the fault still latches.
            if (lut_valid) begin
               cl_data_d  = lut_data;
               cl_valid_d = grant_oh_s;
               state_d    = LUT_ARB_STATE_RESP_OK;
            end else if (lut_invalid) begin
               cl_error_d = grant_oh_s;
               state_d    = LUT_ARB_STATE_RESP_ERR;
            end else if (cnt_q == cnt_last) begin
               fault_d    = 1'b1;
               cl_error_d = grant_oh_s;
               state_d    = LUT_ARB_STATE_RESP_ERR;
            end else begin
               cnt_d = cnt_q + cw'(1);
            end
         end
         LUT_ARB_STATE_RESP_OK: begin
            state_d = LUT_ARB_STATE_IDLE;
         end
         LUT_ARB_STATE_RESP_ERR: begin
            state_d = LUT_ARB_STATE_IDLE;
         end
         LUT_ARB_STATE_FLT: begin
            // Skip a cycle after each strobe so the served client can drop cl_req.
            if ((cl_error_q == {n_clients{1'b0}}) && arb_any_s) begin
               grant_d    = arb_idx_s;
               ptr_d      = iw'(rr_next(int'(arb_idx_s), n_clients));
               cl_error_d = arb_oh_s;
            end else begin
               state_d = LUT_ARB_STATE_FLT;
            end
         end
         default: begin
            state_d = LUT_ARB_STATE_IDLE;
         end
      endcase
   end

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= LUT_ARB_STATE_IDLE;
         ptr_q        <= {iw{1'b0}};
         grant_q      <= {iw{1'b0}};
         cnt_q        <= {cw{1'b0}};
         fault_q      <= 1'b0;
         lut_req_q    <= 1'b0;
         lut_handle_q <= {LUT_HANDLE_WIDTH{1'b0}};
         lut_arg_q    <= {data_width{1'b0}};
         cl_data_q    <= {data_width{1'b0}};
         cl_valid_q   <= {n_clients{1'b0}};
         cl_error_q   <= {n_clients{1'b0}};
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         fault_q      <= fault_d;
         lut_req_q    <= lut_req_d;
         lut_handle_q <= lut_handle_d;
         lut_arg_q    <= lut_arg_d;
         cl_data_q    <= cl_data_d;
         cl_valid_q   <= cl_valid_d;
         cl_error_q   <= cl_error_d;
      end
   end

   assign cl_data    = cl_data_q;
   assign cl_valid   = cl_valid_q;
   assign cl_error   = cl_error_q;
   assign fault      = fault_q;
   assign lut_req    = lut_req_q;
   assign lut_handle = lut_handle_q;
   assign lut_arg    = lut_arg_q;

endmodule

// File: tb/tb_lut_client_arbiter.sv
// Scoreboard bench for lut_client_arbiter with a behavioural responder model.
module tb_lut_client_arbiter;
   import lut_client_arbiter_pkg::*;

   localparam int DW  = 16;
   localparam int NC  = 4;
   localparam int TO  = 8;
   localparam int LAT = 2;

   logic                           clk = 1'b0;
   logic                           reset;
   logic [NC-1:0]                  cl_req;
   logic [NC*LUT_HANDLE_WIDTH-1:0] cl_handle;
   logic [NC*DW-1:0]               cl_arg;
   logic [DW-1:0]                  cl_data;
   logic [NC-1:0]                  cl_valid;
   logic [NC-1:0]                  cl_error;
   logic                           fault;
   logic                           lut_req;
   logic [LUT_HANDLE_WIDTH-1:0]    lut_handle;
   logic [DW-1:0]                  lut_arg;
   logic [DW-1:0]                  lut_data;
   logic                           lut_valid;
   logic                           lut_invalid;

   typedef struct {
      logic [LUT_HANDLE_WIDTH-1:0] h;
      logic [DW-1:0]               a;
   } iss_t;
   typedef struct {
      logic [NC-1:0] v;
      logic [NC-1:0] e;
      logic [DW-1:0] d;
      logic          f;
   } res_t;
   typedef struct {
      int c;
      int n;
   } raise_t;

   iss_t   exp_iss[$];
   res_t   exp_res[$];
   raise_t raise_q[$];

   int n_checks = 0;
   int n_bad    = 0;
   int cyc      = 0;
   int last_raise_cyc  = 0;
   int last_req_cyc    = 0;
   int last_strobe_cyc = 0;
   int mode = 0;   // responder: 0 answer, 1 invalid, 2 silent, 3 valid+invalid

   lut_client_arbiter #(
      .data_width     (DW),
      .n_clients      (NC),
      .timeout_cycles (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cl_req      (cl_req),
      .cl_handle   (cl_handle),
      .cl_arg      (cl_arg),
      .cl_data     (cl_data),
      .cl_valid    (cl_valid),
      .cl_error    (cl_error),
      .fault       (fault),
      .lut_req     (lut_req),
      .lut_handle  (lut_handle),
      .lut_arg     (lut_arg),
      .lut_data    (lut_data),
      .lut_valid   (lut_valid),
      .lut_invalid (lut_invalid)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] resp_val(input logic [LUT_HANDLE_WIDTH-1:0] h, input logic [DW-1:0] a);
      return a ^ 16'hA5A5 ^ {14'd0, h};
   endfunction

   function automatic logic [NC-1:0] oh(input int c);
      return 4'b0001 << c;
   endfunction

   // Responder model, client request driver and output monitor, all on the falling edge.
   initial begin
      int     pcnt;
      logic   pend;
      logic [LUT_HANDLE_WIDTH-1:0] ph;
      logic [DW-1:0] pa;
      int     rereq[NC];
      logic [NC-1:0] arm;
      iss_t   x;
      res_t   r;
      raise_t q;
      pend = 1'b0; pcnt = 0; ph = '0; pa = '0; arm = '0;
      lut_valid = 1'b0; lut_invalid = 1'b0; lut_data = '0; cl_req = '0;
      for (int i = 0; i < NC; i++) rereq[i] = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pend = 1'b0; lut_valid = 1'b0; lut_invalid = 1'b0;
            cl_req = '0; arm = '0;
            for (int i = 0; i < NC; i++) rereq[i] = 0;
         end else begin
            lut_valid = 1'b0;
            if (pend) begin
               pcnt--;
               if (pcnt == 0) begin
                  pend = 1'b0;
                  case (mode)
                     0: begin lut_valid = 1'b1; lut_data = resp_val(ph, pa); end
                     1: lut_invalid = 1'b1;
                     3: begin lut_valid = 1'b1; lut_data = resp_val(ph, pa); lut_invalid = 1'b1; end
                     default: ;
                  endcase
               end
            end
            if (lut_req) begin
               pend = (mode != 2); pcnt = LAT; ph = lut_handle; pa = lut_arg;
               last_req_cyc = cyc;
               check_eq("lut_req_expected", 32'(exp_iss.size() > 0), 32'd1);
               if (exp_iss.size() > 0) begin
                  x = exp_iss.pop_front();
                  check_eq("lut_handle", 32'(lut_handle), 32'(x.h));
                  check_eq("lut_arg", 32'(lut_arg), 32'(x.a));
               end
               check_eq("strobe_with_req", 32'(cl_valid | cl_error), 32'd0);
            end
            for (int i = 0; i < NC; i++) begin
               if (arm[i]) begin cl_req[i] = 1'b1; arm[i] = 1'b0; end
            end
            while (raise_q.size() > 0) begin
               q = raise_q.pop_front();
               cl_req[q.c] = 1'b1;
               rereq[q.c] = q.n;
               last_raise_cyc = cyc;
            end
            if ((cl_valid | cl_error) != '0) begin
               last_strobe_cyc = cyc;
               check_eq("strobe_expected", 32'(exp_res.size() > 0), 32'd1);
               if (exp_res.size() > 0) begin
                  r = exp_res.pop_front();
                  check_eq("cl_valid", 32'(cl_valid), 32'(r.v));
                  check_eq("cl_error", 32'(cl_error), 32'(r.e));
                  check_eq("fault_at_strobe", 32'(fault), 32'(r.f));
                  if (r.v != '0) check_eq("cl_data", 32'(cl_data), 32'(r.d));
               end
               for (int i = 0; i < NC; i++) begin
                  if (cl_valid[i] | cl_error[i]) begin
                     cl_req[i] = 1'b0;
                     if (rereq[i] > 0) begin rereq[i]--; arm[i] = 1'b1; end
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic req(input int c, input logic [LUT_HANDLE_WIDTH-1:0] h, input logic [DW-1:0] a, input int n);
      cl_handle[c*LUT_HANDLE_WIDTH +: LUT_HANDLE_WIDTH] = h;
      cl_arg[c*DW +: DW] = a;
      raise_q.push_back('{c, n});
   endtask

   task automatic expect_ok(input int c, input logic [LUT_HANDLE_WIDTH-1:0] h, input logic [DW-1:0] a, input logic f);
      exp_iss.push_back('{h, a});
      exp_res.push_back('{oh(c), 4'b0000, resp_val(h, a), f});
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((exp_res.size() != 0 || exp_iss.size() != 0) && k < 200) begin
         step();
         k++;
      end
      check_eq(tag, 32'(exp_res.size() + exp_iss.size()), 32'd0);
      repeat (2) step();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_res.delete();
      exp_iss.delete();
      repeat (2) step();
      reset = 1'b1;
      step();
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_cl_valid"}, 32'(cl_valid), 32'd0);
      check_eq({tag, "_cl_error"}, 32'(cl_error), 32'd0);
      check_eq({tag, "_fault"}, 32'(fault), 32'd0);
      check_eq({tag, "_lut_req"}, 32'(lut_req), 32'd0);
      check_eq({tag, "_lut_handle"}, 32'(lut_handle), 32'd0);
      check_eq({tag, "_lut_arg"}, 32'(lut_arg), 32'd0);
      check_eq({tag, "_cl_data"}, 32'(cl_data), 32'd0);
   endtask

   initial begin
      reset = 1'b0; cl_handle = '0; cl_arg = '0; mode = 0;
      repeat (3) step();
      check_outputs_zero("rst");
      reset = 1'b1;
      step();

      // single read from client 0
      expect_ok(0, LUT_HANDLE_SIN, 16'h4000, 1'b0);
      req(0, LUT_HANDLE_SIN, 16'h4000, 0);
      drain("single_done");
      check_eq("req_latency", 32'(last_req_cyc - last_raise_cyc), 32'd1);
      check_eq("valid_latency", 32'(last_strobe_cyc - last_req_cyc), 32'(LAT + 1));

      // clients 1 and 3 together, each re-requesting once: order 1,3,1,3
      for (int k = 0; k < 2; k++) begin
         expect_ok(1, LUT_HANDLE_TANH, 16'h1111, 1'b0);
         expect_ok(3, LUT_HANDLE_SIN, 16'h3333, 1'b0);
      end
      req(1, LUT_HANDLE_TANH, 16'h1111, 1);
      req(3, LUT_HANDLE_SIN, 16'h3333, 1);
      drain("contention_done");

      // invalid handle, then a request while faulted never reaches the responder
      do_reset();
      mode = 1;
      exp_iss.push_back('{2'd3, 16'h0BAD});
      exp_res.push_back('{4'b0000, oh(2), 16'h0000, 1'b1});
      req(2, 2'd3, 16'h0BAD, 0);
      drain("invalid_done");
      check_eq("fault_sticky", 32'(fault), 32'd1);
      exp_res.push_back('{4'b0000, oh(0), 16'h0000, 1'b1});
      req(0, LUT_HANDLE_SIN, 16'h0001, 0);
      drain("flt_done");

      // silent responder: timeout error after TO+1 cycles
      do_reset();
      mode = 2;
      exp_iss.push_back('{LUT_HANDLE_SIN, 16'h7777});
      exp_res.push_back('{4'b0000, oh(3), 16'h0000, 1'b1});
      req(3, LUT_HANDLE_SIN, 16'h7777, 0);
      drain("timeout_done");
      check_eq("timeout_latency", 32'(last_strobe_cyc - last_req_cyc), 32'(TO + 1));

      // valid and invalid together: data delivered, fault set
      do_reset();
      mode = 3;
      expect_ok(1, LUT_HANDLE_TANH, 16'h1234, 1'b1);
      req(1, LUT_HANDLE_TANH, 16'h1234, 0);
      drain("both_done");

      // reset while waiting on the responder
      do_reset();
      mode = 2;
      exp_iss.push_back('{LUT_HANDLE_TANH, 16'h5A5A});
      req(1, LUT_HANDLE_TANH, 16'h5A5A, 0);
      begin
         int k = 0;
         while (exp_iss.size() != 0 && k < 50) begin
            step();
            k++;
         end
      end
      check_eq("wait_issue_seen", 32'(exp_iss.size()), 32'd0);
      repeat (2) step();
      check_eq("wait_handle_held", 32'(lut_handle), 32'(LUT_HANDLE_TANH));
      reset = 1'b0;
      #1;
      check_outputs_zero("midrst");
      exp_res.delete();
      exp_iss.delete();
      repeat (2) step();
      reset = 1'b1;
      mode = 0;
      step();
      expect_ok(0, LUT_HANDLE_SIN, 16'h0F0F, 1'b0);
      expect_ok(3, LUT_HANDLE_TANH, 16'hF0F0, 1'b0);
      req(3, LUT_HANDLE_TANH, 16'hF0F0, 0);
      req(0, LUT_HANDLE_SIN, 16'h0F0F, 0);
      drain("after_reset_done");

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1);
   end

endmodule
